// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing an 8:1 WIDTH-bit mux between eight requesters.
// The selected word is registered and handed downstream over valid/ready, and each transfer is acknowledged with a one-cycle gnt pulse.
module mux8_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       sel,
  output logic [7:0]       gnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [2:0]       sel_reg, sel_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [7:0]       gnt_reg, gnt_next;

  logic [WIDTH-1:0] d_arr [8];
  logic             transfer;
  logic [7:0]       sel_onehot;
  logic [7:0]       elig;
  logic [7:0]       elig_rot;
  logic [2:0]       base;
  logic [2:0]       offset;
  logic [2:0]       winner;
  logic             found;

  assign d_arr[0] = d0;
  assign d_arr[1] = d1;
  assign d_arr[2] = d2;
  assign d_arr[3] = d3;
  assign d_arr[4] = d4;
  assign d_arr[5] = d5;
  assign d_arr[6] = d6;
  assign d_arr[7] = d7;

  assign transfer = (state_reg == HOLD) && ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel_reg == 3'(gi));
    end
  endgenerate

  // The word being transferred and the one just acknowledged are never eligible,
  // so a requester that holds req through its gnt cycle is treated as a fresh request.
  assign elig = req & ~gnt_reg & ~(transfer ? sel_onehot : 8'h00);

  // On a transfer edge the pointer is about to become sel+1; arbitrate with that value already.
  assign base = transfer ? (sel_reg + 3'd1) : ptr_reg;

  // Rotate so that bit 0 of elig_rot is the requester at the search start.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rotate
      logic [2:0] rot_idx;
      assign rot_idx      = base + 3'(gi);
      assign elig_rot[gi] = elig[rot_idx];
    end
  endgenerate

  always_comb begin
    found  = 1'b0;
    offset = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (elig_rot[i]) begin
        found  = 1'b1;
        offset = 3'(i);
      end
    end
  end

  assign winner = base + offset;

  // State register (and registered datapath).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd0;
      sel_reg   <= 3'd0;
      y_reg     <= '0;
      gnt_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      y_reg     <= y_next;
      gnt_reg   <= gnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    y_next     = y_reg;
    gnt_next   = 8'h00;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = HOLD;
          sel_next   = winner;
          y_next     = d_arr[winner];
        end
      end
      HOLD: begin
        if (transfer) begin
          gnt_next = sel_onehot;
          ptr_next = sel_reg + 3'd1;
          if (found) begin
            sel_next = winner;
            y_next   = d_arr[winner];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are straight from registers; y never sees d_i combinationally.
  always_comb begin
    valid = (state_reg == HOLD);
    y     = y_reg;
    sel   = sel_reg;
    gnt   = gnt_reg;
  end

endmodule
